// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: word width, FSM encoding and
// the index-width helper.
package mp_add_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Minimum of 1 so a word index always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Operand/result handshake bundle for mp_add_sequencer; the sub signal only exists when
// MP_ADD_SUBTRACT_EN is defined.
interface mp_add_sequencer_if #(
  parameter int unsigned WORDS = 4
);
  import mp_add_pkg::*;

  localparam int unsigned N = WORD_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         cin;
`ifdef MP_ADD_SUBTRACT_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
`ifdef MP_ADD_SUBTRACT_EN
    output sub,
`endif
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
`ifdef MP_ADD_SUBTRACT_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/mp_add_sequencer_csa.sv
// 16-bit carry-select adder: low half ripples, high half is precomputed for both carries
// and selected by the low-half carry out.
module mp_add_sequencer_csa
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_c,
  output logic [WORD_W-1:0] o_s,
  output logic              o_c
);
  localparam int unsigned HalfW = WORD_W / 2;

  logic [HalfW:0] w_lo;
  logic [HalfW:0] w_hi0;
  logic [HalfW:0] w_hi1;
  logic [HalfW:0] w_hi;

  assign w_lo  = {1'b0, i_a[HalfW-1:0]} + {1'b0, i_b[HalfW-1:0]} + {{HalfW{1'b0}}, i_c};
  assign w_hi0 = {1'b0, i_a[WORD_W-1:HalfW]} + {1'b0, i_b[WORD_W-1:HalfW]};
  assign w_hi1 = {1'b0, i_a[WORD_W-1:HalfW]} + {1'b0, i_b[WORD_W-1:HalfW]} + (HalfW + 1)'(1);
  assign w_hi  = w_lo[HalfW] ? w_hi1 : w_hi0;

  assign o_s = {w_hi[HalfW-1:0], w_lo[HalfW-1:0]};
  assign o_c = w_hi[HalfW];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: runs one shared 16-bit adder over WORDS cycles, LS word first.
// Define MP_ADD_SUBTRACT_EN to add the sub input (A - B via inverted B and forced carry-in).
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input logic               clk,
  input logic               rst,
  mp_add_sequencer_if.slave bus
);
  localparam int unsigned N    = WORD_W * WORDS;
  localparam int unsigned IdxW = clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e            r_state;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic [N-1:0]      r_sum;
  logic [IdxW-1:0]   r_idx;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic              r_out_valid;
  logic              r_busy;

  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_b_eff;
  logic [WORD_W-1:0] w_s;
  logic              w_c;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_carry_in;

  assign w_a_word = r_a[r_idx*WORD_W +: WORD_W];
  assign w_b_word = r_b[r_idx*WORD_W +: WORD_W];

`ifdef MP_ADD_SUBTRACT_EN
  logic r_sub;
  assign w_b_eff    = r_sub ? ~w_b_word : w_b_word;
  assign w_carry_in = bus.sub | bus.cin;
`else
  assign w_b_eff    = w_b_word;
  assign w_carry_in = bus.cin;
`endif

  // In DONE the slot frees up in the same cycle the consumer takes the result.
  assign w_in_ready = (r_state == StIdle) || ((r_state == StDone) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  mp_add_sequencer_csa u_csa (
    .i_a (w_a_word),
    .i_b (w_b_eff),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MP_ADD_SUBTRACT_EN
      r_sub       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a         <= bus.op_a;
      r_b         <= bus.op_b;
      r_carry     <= w_carry_in;
      r_idx       <= '0;
      r_state     <= StRun;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef MP_ADD_SUBTRACT_EN
      r_sub       <= bus.sub;
`endif
    end else begin
      unique case (r_state)
        StIdle: ;
        StRun: begin
          r_sum[r_idx*WORD_W +: WORD_W] <= w_s;
          r_carry <= w_c;
          if (r_idx == LastIdx) begin
            r_cout      <= w_c;
            r_ovf       <= (w_a_word[WORD_W-1] == w_b_eff[WORD_W-1]) &&
                           (w_s[WORD_W-1] != w_a_word[WORD_W-1]);
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer (WORDS=4) with a scoreboard of expected results.
module tb_mp_add_sequencer;
  import mp_add_pkg::*;

  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = WORD_W * WORDS;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  mp_add_sequencer_if #(.WORDS(WORDS)) bus ();

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full-width addition of A and the effective B plus carry-in.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input logic s);
    exp_t         e;
    logic [N-1:0] be;
    logic [N:0]   t;
    be     = s ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, (s ? 1'b1 : c)};
    e.sum  = t[N-1:0];
    e.cout = t[N];
    e.ovf  = (a[N-1] == be[N-1]) && (t[N-1] != a[N-1]);
    return e;
  endfunction

  task automatic drive_ops(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic c, input logic s);
    bus.op_a = a;
    bus.op_b = b;
    bus.cin  = c;
`ifdef MP_ADD_SUBTRACT_EN
    bus.sub  = s;
`endif
  endtask

  // Returns at accept edge + 1 time unit with in_valid dropped.
  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input logic s);
    int w;
    w = 0;
    @(negedge clk);
    drive_ops(a, b, c, s);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_bit("accept_ready", bus.in_ready, 1'b1);
    sb.push_back(model(a, b, c, s));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int(tag, lat, exp_lat);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard entries observed 0 expected 1", tag);
      return;
    end
    e = sb.pop_front();
    check_bit({tag, "_valid"}, bus.out_valid, 1'b1);
    check_word({tag, "_sum"}, bus.sum, e.sum);
    check_bit({tag, "_cout"}, bus.cout, e.cout);
    check_bit({tag, "_ovf"}, bus.ovf, e.ovf);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_bit({tag, "_released"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time observed 200000 expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_word("rst_sum", bus.sum, '0);
    check_bit("rst_cout", bus.cout, 1'b0);
    check_bit("rst_ovf", bus.ovf, 1'b0);

    // Carry ripples through all four words.
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    check_bit("run_busy", bus.busy, 1'b1);
    check_bit("run_in_ready", bus.in_ready, 1'b0);
    wait_out("ripple_latency", 4);
    collect("ripple");

    // Signed overflow.
    accept(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    wait_out("ovf_latency", 4);
    collect("ovf");

    // Carry-in honoured.
    accept(64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b1, 1'b0);
    wait_out("cin_latency", 4);
    collect("cin");

    // Back-pressure, then back-to-back accept on the handshake cycle.
    accept(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_out("bp_latency", 4);
    e = sb[0];
    drive_ops(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_word("bp_sum_hold", bus.sum, e.sum);
      check_bit("bp_in_ready_hold", bus.in_ready, 1'b0);
      check_bit("bp_valid_hold", bus.out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    check_word("bp_sum", bus.sum, e.sum);
    check_bit("bp_cout", bus.cout, e.cout);
    check_bit("bp_ovf", bus.ovf, e.ovf);
    bus.out_ready = 1'b1;
    #1;
    check_bit("bp_in_ready_release", bus.in_ready, 1'b1);
    sb.push_back(model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_bit("bp2_released", bus.out_valid, 1'b0);
    check_bit("bp2_direct_run", bus.busy, 1'b1);
    wait_out("bp2_latency", 4);
    collect("bp2");

    // Reset on the second RUN cycle aborts without a result.
    accept(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check_bit("abort_in_ready", bus.in_ready, 1'b1);
    check_bit("abort_out_valid", bus.out_valid, 1'b0);
    check_bit("abort_busy", bus.busy, 1'b0);
    check_word("abort_sum", bus.sum, '0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_int("abort_no_result", seen, 0);

    // Operand changes during RUN are ignored; sum retained in IDLE afterwards.
    accept(64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b0);
    drive_ops('0, '1, 1'b1, 1'b0);
    e = sb[0];
    wait_out("stable_latency", 4);
    collect("stable");
    @(posedge clk);
    #1;
    check_word("idle_sum_retained", bus.sum, e.sum);

`ifdef MP_ADD_SUBTRACT_EN
    accept(64'd5, 64'd7, 1'b0, 1'b1);
    wait_out("sub_neg_latency", 4);
    collect("sub_neg");
    accept(64'd7, 64'd5, 1'b0, 1'b1);
    wait_out("sub_pos_latency", 4);
    collect("sub_pos");
`endif

    check_int("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
